// File: rtl/cu_pkg.sv
// cu_pkg: opcode/func/ALU_op constants and control bundle shared by control_unit and cu_alu_dec
package cu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef struct packed {
    logic reg_dst;
    logic reg_write;
    logic alu_src;
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
    logic branch;
  } ctrl_t;
  localparam ctrl_t CTRL_NONE = '0;
endpackage

// File: rtl/cu_alu_dec.sv
// cu_alu_dec: maps (op, func) to ALU_op and flags legal R-type func; CU_IMM_LOGIC_EN adds andi/ori/slti
module cu_alu_dec
  import cu_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output logic [2:0] o_alu_op,
  output logic       o_r_legal
);
  logic [2:0] w_r_alu;
  logic [2:0] w_i_alu;
  assign w_r_alu = i_func == FN_SUB ? ALU_SUB :
                   i_func == FN_AND ? ALU_AND :
                   i_func == FN_OR  ? ALU_OR  :
                   i_func == FN_SLT ? ALU_SLT : ALU_ADD;
  assign o_r_legal = i_func inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
`ifdef CU_IMM_LOGIC_EN
  assign w_i_alu = i_op == OP_ANDI ? ALU_AND :
                   i_op == OP_ORI  ? ALU_OR  :
                   i_op == OP_SLTI ? ALU_SLT : ALU_ADD;
`else
  assign w_i_alu = ALU_ADD;
`endif
  assign o_alu_op = i_op == OP_RTYPE ? w_r_alu :
                    i_op == OP_BEQ   ? ALU_SUB : w_i_alu;
endmodule

// File: rtl/control_unit.sv
// control_unit: registered MIPS-subset main decoder; CU_IMM_LOGIC_EN enables andi/ori/slti
module control_unit
  import cu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       MemtoReg,
  output logic       Branch,
  output logic [2:0] ALU_op
);
  ctrl_t      w_ctrl;
  ctrl_t      r_ctrl;
  logic [2:0] w_alu_op;
  logic [2:0] r_alu_op;
  logic       w_r_legal;
  cu_alu_dec u_alu_dec (
    .i_op     (op),
    .i_func   (func),
    .o_alu_op (w_alu_op),
    .o_r_legal(w_r_legal)
  );
  // Unknown opcodes and illegal R-type funcs fall through to CTRL_NONE: no writes
  always_comb begin
    w_ctrl = CTRL_NONE;
    case (op)
      OP_RTYPE: if (w_r_legal) w_ctrl = '{reg_dst: 1'b1, reg_write: 1'b1, default: 1'b0};
      OP_LW:    w_ctrl = '{reg_write: 1'b1, alu_src: 1'b1, mem_read: 1'b1, mem_to_reg: 1'b1, default: 1'b0};
      OP_SW:    w_ctrl = '{alu_src: 1'b1, mem_write: 1'b1, default: 1'b0};
      OP_BEQ:   w_ctrl = '{branch: 1'b1, default: 1'b0};
      OP_ADDI:  w_ctrl = '{reg_write: 1'b1, alu_src: 1'b1, default: 1'b0};
`ifdef CU_IMM_LOGIC_EN
      OP_ANDI, OP_ORI, OP_SLTI: w_ctrl = '{reg_write: 1'b1, alu_src: 1'b1, default: 1'b0};
`endif
      default:  w_ctrl = CTRL_NONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl   <= CTRL_NONE;
      r_alu_op <= 3'b000;
    end else begin
      r_ctrl   <= w_ctrl;
      r_alu_op <= w_alu_op;
    end
  end
  assign RegDst   = r_ctrl.reg_dst;
  assign RegWrite = r_ctrl.reg_write;
  assign ALUSrc   = r_ctrl.alu_src;
  assign MemWrite = r_ctrl.mem_write;
  assign MemRead  = r_ctrl.mem_read;
  assign MemtoReg = r_ctrl.mem_to_reg;
  assign Branch   = r_ctrl.branch;
  assign ALU_op   = r_alu_op;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit; expectations follow CU_IMM_LOGIC_EN when defined
module tb_control_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'b100011;
  logic [5:0] func = 6'b000000;
  logic       RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, Branch;
  logic [2:0] ALU_op;
  typedef struct {
    string      name;
    logic [9:0] exp;
  } exp_t;
  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   done = 1'b0;
  control_unit dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemtoReg(MemtoReg), .Branch(Branch), .ALU_op(ALU_op)
  );
  always #5 clk = ~clk;
  // Expected vector layout: {RegDst,RegWrite,ALUSrc,MemWrite,MemRead,MemtoReg,Branch,ALU_op}
  task automatic step(input string name, input logic rst, input logic [5:0] o, input logic [5:0] f,
                      input logic [6:0] c, input logic [2:0] a);
    exp_t e;
    @(negedge clk);
    rst_n = rst;
    op = o;
    func = f;
    e.name = name;
    e.exp = {c, a};
    q.push_back(e);
  endtask
  initial begin
    exp_t       e;
    logic [9:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        act = {RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, Branch, ALU_op};
        n_checks++;
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got %b required %b", e.name, act, e.exp);
      end
    end
  end
  initial begin
    step("reset0",   1'b0, 6'b100011, 6'b000000, 7'b0000000, 3'b000);
    step("reset1",   1'b0, 6'b100011, 6'b000000, 7'b0000000, 3'b000);
    step("r_add",    1'b1, 6'b000000, 6'b100000, 7'b1100000, 3'b010);
    step("r_sub",    1'b1, 6'b000000, 6'b100010, 7'b1100000, 3'b110);
    step("r_and",    1'b1, 6'b000000, 6'b100100, 7'b1100000, 3'b000);
    step("r_or",     1'b1, 6'b000000, 6'b100101, 7'b1100000, 3'b001);
    step("r_slt",    1'b1, 6'b000000, 6'b101010, 7'b1100000, 3'b111);
    step("lw",       1'b1, 6'b100011, 6'b000000, 7'b0110110, 3'b010);
    step("sw",       1'b1, 6'b101011, 6'b111111, 7'b0011000, 3'b010);
    step("beq_f2a",  1'b1, 6'b000100, 6'b101010, 7'b0000001, 3'b110);
    step("beq_f00",  1'b1, 6'b000100, 6'b000000, 7'b0000001, 3'b110);
    step("addi",     1'b1, 6'b001000, 6'b100010, 7'b0110000, 3'b010);
    step("ill_op",   1'b1, 6'b111111, 6'b100000, 7'b0000000, 3'b010);
    step("ill_func", 1'b1, 6'b000000, 6'b000000, 7'b0000000, 3'b010);
    step("ill_f2b",  1'b1, 6'b000000, 6'b100011, 7'b0000000, 3'b010);
`ifdef CU_IMM_LOGIC_EN
    step("ori",      1'b1, 6'b001101, 6'b000000, 7'b0110000, 3'b001);
    step("andi",     1'b1, 6'b001100, 6'b000000, 7'b0110000, 3'b000);
    step("slti",     1'b1, 6'b001010, 6'b000000, 7'b0110000, 3'b111);
`else
    step("ori",      1'b1, 6'b001101, 6'b000000, 7'b0000000, 3'b010);
    step("andi",     1'b1, 6'b001100, 6'b000000, 7'b0000000, 3'b010);
    step("slti",     1'b1, 6'b001010, 6'b000000, 7'b0000000, 3'b010);
`endif
    step("mid_rst",  1'b0, 6'b000000, 6'b101010, 7'b0000000, 3'b000);
    step("post_lw",  1'b1, 6'b100011, 6'b000000, 7'b0110110, 3'b010);
    step("post_sw",  1'b1, 6'b101011, 6'b000000, 7'b0011000, 3'b010);
    step("post_beq", 1'b1, 6'b000100, 6'b000000, 7'b0000001, 3'b110);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
